channel_estimator_lms: RTL and testbench
========================================

// Module: channel_estimator_lms
// PURPOSE
// Sign-data LMS estimator that adapts the channel taps consumed by channel_filter.
// Compares ADC codes with channel_filter's est_code and correlates the error with the symbol window.
// Integrates the result into one shared tap set of depth taps; the tap set is broadcast to all width lanes.
// Sits beside channel_filter, with its output feeding channel_filter's channel input.
// PARAMETERS
// width                 16  lanes (symbols) per clock
// depth                 30  channel taps
// sym_bitwidth           2  signed symbol width
// code_bitwidth          8  signed ADC code width
// est_code_bitwidth      8  signed est_code width (from channel_filter)
// est_channel_bitwidth   8  signed output tap width
// frac_bits              8  extra LSBs held in tap accumulators
// gain_bitwidth          4  width of gain (right shift of gradient)
// period_bitwidth        8  width of update_period
// PORTS
// clk             in   1                              clock; all state changes on rising edge
// rstb            in   1                              asynchronous active-low reset
// en              in   1                              adaptation enable (level)
// load            in   1                              one-cycle pulse: load init_channel
// init_channel    in   [depth] x est_channel_bitwidth initial taps, signed
// gain            in   gain_bitwidth                  step size = 2^-gain
// update_period   in   period_bitwidth                updates every update_period+1 cycles
// codes           in   [width] x code_bitwidth        ADC codes, signed
// est_code        in   [width] x est_code_bitwidth    channel_filter output for the same cycle's symbols
// symstream       in   [depth-1+width] x sym_bitwidth same window that drives channel_filter
// channel         out  [width][depth] x est_channel_bitwidth  tap estimate, identical across lanes
// busy            out  1                              state != IDLE
// update_count    out  16                             completed updates, saturating
// BEHAVIOUR
// Reset (rstb=0, async)
// - Accumulators, pipeline and update_count clear to 0; decim_cnt clears to 0.
// - channel=0, busy=0, state IDLE.
// Accumulators
// - acc[j] is signed, est_channel_bitwidth+frac_bits bits.
// - channel[i][j] = acc[j] >>> frac_bits, for every lane i.
// States
// - IDLE -> TRAIN: when en=1.
// - TRAIN -> DRAIN: when en=0.
// - DRAIN -> IDLE: after 2 cycles, which retires the in-flight updates.
// - DRAIN -> TRAIN: when en rises during DRAIN; decim_cnt restarts from 0.
// Decimation
// - In TRAIN, decim_cnt counts 0..update_period and then wraps to 0.
// - A sample is taken only on cycles where decim_cnt==0.
// - update_period=0 gives one update per cycle.
// Pipeline (sample taken at edge N)
// - S1, edge N: err[i] = codes[i] - est_code[i], held at code_bitwidth+1 bits (wide enough to avoid overflow).
//   The symbol window is registered alongside.
// - S2, edge N+1: grad[j] = sum_i err[i]*sign(sym[i+depth-1-j]).
//   sign() gives +1 for sym>0, -1 for sym<0, 0 for sym==0; the sum is full precision.
// - S3, edge N+2: acc[j] <= sat(acc[j] + (grad[j] >>> gain)).
//   sat clamps to [-2^(W-1), 2^(W-1)-1], where W is the accumulator width.
//   update_count increments, holding at 16'hFFFF.
// - The result is visible on channel after edge N+2, i.e. latency 3 cycles from sample.
// - A new sample may enter every cycle.
// load
// - acc[j] <= init_channel[j] << frac_bits.
// - S1/S2 valid bits clear; update_count clears; state becomes IDLE; decim_cnt clears.
// - load overrides any simultaneous S3 update and any en assertion in the same cycle.
// en drop mid-pipeline
// - Samples already taken still complete in DRAIN; no new samples are taken.
// IDLE
// - acc holds; codes, est_code and symstream are ignored.
// gain and update_period
// - Sampled each cycle, not latched.
// - A change takes effect for the next sample.
// TESTING
// 1. Reset: assert rstb=0 mid-TRAIN -> channel=0, busy=0 and update_count=0 immediately (async).
// 2. Load init_channel[j]=j-15 -> next cycle channel[i][j]=j-15 for all i; busy=0.
// 3. Zero error: en=1, codes==est_code, 100 cycles -> taps unchanged; update_count=100.
// 4. Single update at frac_bits=8, gain=0, update_period=0:
//    - Stimulus: all sym=+1, every err=+16, en high for exactly 1 cycle.
//    - Required: grad=256; after 3 cycles acc[j]+=256, so every tap +1; then DRAIN -> IDLE.
// 5. Saturation: init all taps 127, then drive positive gradients -> taps hold at 127 and never wrap to -128.
// 6. Decimation/collision:
//    - update_period=3: update_count steps once per 4 cycles.
//    - load pulsed on the same edge as an S3 update -> init values win; update_count=0.

Source files
------------

// File: rtl/channel_estimator_lms.sv
// Sign-data LMS channel estimator: correlates (codes - est_code) with the sign of the
// symbol window and integrates the gradient into one shared, saturating tap set.
module channel_estimator_lms #(
    parameter int width                = 16,
    parameter int depth                = 30,
    parameter int sym_bitwidth         = 2,
    parameter int code_bitwidth        = 8,
    parameter int est_code_bitwidth    = 8,
    parameter int est_channel_bitwidth = 8,
    parameter int frac_bits            = 8,
    parameter int gain_bitwidth        = 4,
    parameter int period_bitwidth      = 8
) (
    input  logic                                              clk,
    input  logic                                              rstb,
    input  logic                                              en,
    input  logic                                              load,
    input  logic [depth*est_channel_bitwidth-1:0]             init_channel,
    input  logic [gain_bitwidth-1:0]                          gain,
    input  logic [period_bitwidth-1:0]                        update_period,
    input  logic [width*code_bitwidth-1:0]                    codes,
    input  logic [width*est_code_bitwidth-1:0]                est_code,
    input  logic [(depth-1+width)*sym_bitwidth-1:0]           symstream,
    output logic [width*depth*est_channel_bitwidth-1:0]       channel,
    output logic                                              busy,
    output logic [15:0]                                       update_count
);
    localparam int NSYM   = depth - 1 + width;
    localparam int IN_W   = (code_bitwidth > est_code_bitwidth) ? code_bitwidth : est_code_bitwidth;
    localparam int ERR_W  = IN_W + 1;
    localparam int GRAD_W = ERR_W + $clog2(width) + 1;
    localparam int ACC_W  = est_channel_bitwidth + frac_bits;
    localparam int SUM_W  = ((GRAD_W > ACC_W) ? GRAD_W : ACC_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_DRAIN} state_t;

    state_t                        r_state, w_state_nxt;
    logic                          r_drain_cnt;
    logic [period_bitwidth-1:0]    r_decim, w_cnt_eff, w_decim_nxt;
    logic                          w_sample;
    logic                          r_vld_p0, r_vld_p1;
    logic signed [ERR_W-1:0]       w_err [width];
    logic signed [ERR_W-1:0]       r_err_p0 [width];
    logic [NSYM*sym_bitwidth-1:0]  r_sym_p0;
    logic signed [GRAD_W-1:0]      w_grad [depth];
    logic signed [GRAD_W-1:0]      r_grad_p1 [depth];
    logic signed [ACC_W-1:0]       r_acc [depth];
    logic [15:0]                   r_update_count;

    function automatic logic signed [ACC_W-1:0] f_sat(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
        lo = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        if (x > hi)      f_sat = hi[ACC_W-1:0];
        else if (x < lo) f_sat = lo[ACC_W-1:0];
        else             f_sat = x[ACC_W-1:0];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_TRAIN;
            S_TRAIN: if (!en) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)               w_state_nxt = S_TRAIN;
                else if (r_drain_cnt) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Entering TRAIN (from IDLE or DRAIN) behaves as decim_cnt==0, so the first en cycle samples.
    always_comb begin
        w_cnt_eff   = (r_state == S_TRAIN) ? r_decim : '0;
        w_sample    = en && (w_cnt_eff == '0);
        w_decim_nxt = '0;
        if (en && (w_cnt_eff < update_period))
            w_decim_nxt = w_cnt_eff + 1'b1;
    end

    always_comb begin
        for (int i = 0; i < width; i++)
            w_err[i] = ERR_W'($signed(codes[i*code_bitwidth +: code_bitwidth]))
                     - ERR_W'($signed(est_code[i*est_code_bitwidth +: est_code_bitwidth]));
    end

    always_comb begin
        for (int j = 0; j < depth; j++) begin
            w_grad[j] = '0;
            for (int i = 0; i < width; i++) begin
                if ($signed(r_sym_p0[(i+depth-1-j)*sym_bitwidth +: sym_bitwidth]) > 0)
                    w_grad[j] = w_grad[j] + GRAD_W'(r_err_p0[i]);
                else if ($signed(r_sym_p0[(i+depth-1-j)*sym_bitwidth +: sym_bitwidth]) < 0)
                    w_grad[j] = w_grad[j] - GRAD_W'(r_err_p0[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state        <= S_IDLE;
            r_drain_cnt    <= 1'b0;
            r_decim        <= '0;
            r_vld_p0       <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_update_count <= '0;
            r_sym_p0       <= '0;
            for (int i = 0; i < width; i++) r_err_p0[i] <= '0;
            for (int j = 0; j < depth; j++) begin
                r_grad_p1[j] <= '0;
                r_acc[j]     <= '0;
            end
        end else if (load) begin
            r_state        <= S_IDLE;
            r_drain_cnt    <= 1'b0;
            r_decim        <= '0;
            r_vld_p0       <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_update_count <= '0;
            for (int j = 0; j < depth; j++)
                r_acc[j] <= {init_channel[j*est_channel_bitwidth +: est_channel_bitwidth],
                             {frac_bits{1'b0}}};
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_decim     <= w_decim_nxt;
            // S1: error and symbol window capture
            r_vld_p0 <= w_sample;
            if (w_sample) begin
                r_sym_p0 <= symstream;
                for (int i = 0; i < width; i++) r_err_p0[i] <= w_err[i];
            end
            // S2: sign-data gradient
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0)
                for (int j = 0; j < depth; j++) r_grad_p1[j] <= w_grad[j];
            // S3: scaled, saturating integration
            if (r_vld_p1) begin
                for (int j = 0; j < depth; j++)
                    r_acc[j] <= f_sat(SUM_W'(r_acc[j]) + SUM_W'(r_grad_p1[j] >>> gain));
                if (r_update_count != 16'hFFFF)
                    r_update_count <= r_update_count + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < width; gi++) begin : g_lane
        for (genvar gj = 0; gj < depth; gj++) begin : g_tap
            assign channel[(gi*depth+gj)*est_channel_bitwidth +: est_channel_bitwidth] =
                r_acc[gj][ACC_W-1 -: est_channel_bitwidth];
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign update_count = r_update_count;
endmodule

// File: tb/tb_channel_estimator_lms.sv
// Directed bench for channel_estimator_lms: reset, load, adaptation arithmetic,
// saturation, decimation and load/update collision.
module tb_channel_estimator_lms;
    localparam int W = 16, D = 30, SB = 2, CB = 8, EB = 8, CHB = 8, GB = 4, PB = 8;
    localparam int NS = D - 1 + W;

    logic                  clk = 1'b0;
    logic                  rstb, en, load;
    logic [D*CHB-1:0]      init_channel;
    logic [GB-1:0]         gain;
    logic [PB-1:0]         update_period;
    logic [W*CB-1:0]       codes;
    logic [W*EB-1:0]       est_code;
    logic [NS*SB-1:0]      symstream;
    logic [W*D*CHB-1:0]    channel;
    logic                  busy;
    logic [15:0]           update_count;

    int n_tests = 0;
    int n_fail  = 0;

    channel_estimator_lms dut (
        .clk(clk), .rstb(rstb), .en(en), .load(load), .init_channel(init_channel),
        .gain(gain), .update_period(update_period), .codes(codes), .est_code(est_code),
        .symstream(symstream), .channel(channel), .busy(busy), .update_count(update_count)
    );

    always #5 clk = ~clk;

    function automatic int tap(input int i, input int j);
        logic signed [CHB-1:0] v;
        v = channel[(i*D+j)*CHB +: CHB];
        return int'(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_err(input int c, input int e);
        for (int i = 0; i < W; i++) begin
            codes[i*CB +: CB]    = CB'(c);
            est_code[i*EB +: EB] = EB'(e);
        end
    endtask

    task automatic set_sym_all(input logic [SB-1:0] v);
        for (int k = 0; k < NS; k++) symstream[k*SB +: SB] = v;
    endtask

    task automatic load_all(input int v);
        for (int j = 0; j < D; j++) init_channel[j*CHB +: CHB] = CHB'(v);
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (tap(0, 0) !== 0 || tap(W-1, D-1) !== 0 || busy !== 1'b0 || update_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: tap=%0d busy=%0b count=%0d, required 0/0/0",
                     tap(0, 0), busy, update_count);
        end
    endtask

    task automatic test_load();
        int bad;
        for (int j = 0; j < D; j++) init_channel[j*CHB +: CHB] = CHB'(j - 15);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < D; j++)
                if (tap(i, j) !== j - 15) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL load_taps: %0d taps wrong, tap[3][0]=%0d required -15", bad, tap(3, 0));
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_busy: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_zero_error();
        int bad;
        for (int i = 0; i < W; i++) begin
            codes[i*CB +: CB]    = CB'(i*7 - 50);
            est_code[i*EB +: EB] = EB'(i*7 - 50);
        end
        for (int k = 0; k < NS; k++) symstream[k*SB +: SB] = (k % 3 == 0) ? 2'b11 : 2'b01;
        en = 1'b1;
        tick(100);
        en = 1'b0;
        tick(4);
        bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < D; j++)
                if (tap(i, j) !== j - 15) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL zero_err_taps: %0d taps changed, tap[0][29]=%0d required 14", bad, tap(0, 29));
        end
        n_tests++;
        if (update_count !== 16'd100) begin
            n_fail++;
            $display("FAIL zero_err_count: count=%0d required 100", update_count);
        end
    endtask

    task automatic test_single_update();
        int bad;
        set_err(16, 0);
        set_sym_all(2'b01);
        gain = '0;
        update_period = '0;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_train: busy=%0b required 1", busy);
        end
        tick(1);
        n_tests++;
        if (tap(0, 0) !== -15) begin
            n_fail++;
            $display("FAIL single_latency: tap[0][0]=%0d required -15 one edge after sample", tap(0, 0));
        end
        tick(1);
        bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < D; j++)
                if (tap(i, j) !== j - 14) bad++;
        n_tests++;
        if (bad != 0 || update_count !== 16'd101) begin
            n_fail++;
            $display("FAIL single_update: %0d taps wrong, tap[0][0]=%0d required -14, count=%0d required 101",
                     bad, tap(0, 0), update_count);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_drain: busy=%0b required 1", busy);
        end
        tick(1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%0b required 0", busy);
        end
        set_err(100, -100);
        tick(5);
        n_tests++;
        if (tap(5, 7) !== -7 || update_count !== 16'd101) begin
            n_fail++;
            $display("FAIL idle_hold: tap[5][7]=%0d required -7, count=%0d required 101", tap(5, 7), update_count);
        end
    endtask

    task automatic test_window();
        int bad;
        load_all(0);
        set_sym_all(2'b00);
        symstream[(D-1)*SB +: SB] = 2'b01;
        set_err(127, -128);
        en = 1'b1;
        tick(2);
        en = 1'b0;
        tick(4);
        bad = 0;
        for (int j = 0; j < D; j++)
            if (tap(2, j) !== ((j < W) ? 1 : 0)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL window_pos: %0d taps wrong, tap[2][0]=%0d required 1, tap[2][20]=%0d required 0",
                     bad, tap(2, 0), tap(2, 20));
        end
        load_all(0);
        symstream[(D-1)*SB +: SB] = 2'b11;
        en = 1'b1;
        tick(2);
        en = 1'b0;
        tick(4);
        bad = 0;
        for (int j = 0; j < D; j++)
            if (tap(9, j) !== ((j < W) ? -2 : 0)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL window_neg: %0d taps wrong, tap[9][0]=%0d required -2", bad, tap(9, 0));
        end
    endtask

    task automatic test_gain();
        load_all(0);
        set_sym_all(2'b01);
        set_err(16, 0);
        gain = 4'd2;
        en = 1'b1;
        tick(4);
        en = 1'b0;
        tick(4);
        n_tests++;
        if (tap(0, 0) !== 1 || tap(W-1, D-1) !== 1 || update_count !== 16'd4) begin
            n_fail++;
            $display("FAIL gain_shift: tap=%0d/%0d required 1/1, count=%0d required 4",
                     tap(0, 0), tap(W-1, D-1), update_count);
        end
        gain = '0;
    endtask

    task automatic test_saturation();
        int bad;
        load_all(127);
        set_sym_all(2'b01);
        set_err(127, -128);
        en = 1'b1;
        tick(20);
        en = 1'b0;
        tick(4);
        bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < D; j++)
                if (tap(i, j) !== 127) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_pos: %0d taps wrong, tap[0][0]=%0d required 127", bad, tap(0, 0));
        end
        load_all(-128);
        set_sym_all(2'b11);
        en = 1'b1;
        tick(20);
        en = 1'b0;
        tick(4);
        n_tests++;
        if (tap(0, 0) !== -128 || tap(W-1, D-1) !== -128) begin
            n_fail++;
            $display("FAIL sat_neg: tap=%0d/%0d required -128", tap(0, 0), tap(W-1, D-1));
        end
    endtask

    task automatic test_decimation();
        load_all(0);
        set_err(5, 5);
        update_period = 8'd3;
        en = 1'b1;
        tick(9);
        n_tests++;
        if (update_count !== 16'd2) begin
            n_fail++;
            $display("FAIL decim_mid: count=%0d required 2", update_count);
        end
        tick(7);
        en = 1'b0;
        tick(4);
        n_tests++;
        if (update_count !== 16'd4) begin
            n_fail++;
            $display("FAIL decim_total: count=%0d required 4", update_count);
        end
        update_period = '0;
    endtask

    task automatic test_collision();
        load_all(0);
        set_sym_all(2'b01);
        set_err(16, 0);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(1);
        for (int j = 0; j < D; j++) init_channel[j*CHB +: CHB] = CHB'(5);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        n_tests++;
        if (tap(0, 0) !== 5 || tap(W-1, D-1) !== 5 || update_count !== 16'd0) begin
            n_fail++;
            $display("FAIL collision_load: tap=%0d/%0d required 5, count=%0d required 0",
                     tap(0, 0), tap(W-1, D-1), update_count);
        end
        tick(3);
        n_tests++;
        if (tap(4, 4) !== 5 || update_count !== 16'd0) begin
            n_fail++;
            $display("FAIL collision_flush: tap=%0d required 5, count=%0d required 0", tap(4, 4), update_count);
        end
        en = 1'b1;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        en = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_en: busy=%0b required 0", busy);
        end
        tick(4);
    endtask

    task automatic test_async_reset();
        load_all(3);
        set_sym_all(2'b01);
        set_err(16, 0);
        en = 1'b1;
        tick(5);
        n_tests++;
        if (busy !== 1'b1 || update_count !== 16'd3 || tap(0, 0) !== 6) begin
            n_fail++;
            $display("FAIL train_progress: busy=%0b count=%0d tap=%0d required 1/3/6", busy, update_count, tap(0, 0));
        end
        #2;
        rstb = 1'b0;
        #1;
        n_tests++;
        if (tap(0, 0) !== 0 || tap(W-1, D-1) !== 0 || busy !== 1'b0 || update_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: tap=%0d busy=%0b count=%0d required 0/0/0", tap(0, 0), busy, update_count);
        end
        en = 1'b0;
        tick(1);
        rstb = 1'b1;
        tick(1);
    endtask

    initial begin
        rstb = 1'b0;
        en = 1'b0;
        load = 1'b0;
        init_channel = '0;
        gain = '0;
        update_period = '0;
        codes = '0;
        est_code = '0;
        symstream = '0;
        tick(2);
        test_reset();
        rstb = 1'b1;
        tick(1);
        test_load();
        test_zero_error();
        test_single_update();
        test_window();
        test_gain();
        test_saturation();
        test_decimation();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
